// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 constants and types: forward S-box, round
//                constants, round-key type, key-schedule FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef logic [AES_KEY_W-1:0] round_key_t;

    // Explicit 2-bit encoding keeps the state register width fixed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } ks_state_t;

    localparam logic [7:0] RC [AES_NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // RotWord: the most significant byte wraps round to the least significant.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sub_word
//  Description : SubWord -- four parallel forward S-box lookups on a 32-bit
//                word. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                     SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_key_sched
//  Description : AES-128 inverse key schedule. Expands the cipher key forward
//                to K10, then walks back one round key per rk handshake,
//                emitting K10 first and K0 last. No round-key storage.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_idx,
    output logic             rk_last,
    output logic             busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    ks_state_t  state_q, state_d;
    round_key_t key_q,   key_d;
    logic [3:0] rnd_q,   rnd_d;

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_v3;
    logic [31:0] w_sub_in, w_sub_out;
    logic [3:0]  w_rc_idx;
    logic [7:0]  w_rc;
    logic [31:0] w_g;
    logic [31:0] w_f0, w_f1, w_f2, w_f3;
    round_key_t  w_fwd_key, w_inv_key;

    assign w_w0 = key_q[127:96];
    assign w_w1 = key_q[95:64];
    assign w_w2 = key_q[63:32];
    assign w_w3 = key_q[31:0];

    // Going backwards, the previous key's w3 is recovered as w3^w2 and fed to g.
    assign w_v3     = w_w3 ^ w_w2;
    assign w_sub_in = (state_q == EMIT) ? w_v3 : w_w3;

    // One shared S-box word; FWD and EMIT are mutually exclusive.
    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // The counter equals r in both phases, so RC[r-1] serves both directions.
    assign w_rc_idx = rnd_q - 4'd1;
    assign w_rc     = ((rnd_q != 4'd0) && (rnd_q <= LAST_RND)) ? RC[w_rc_idx] : 8'h00;

    // SubWord is bytewise, so rotating after substitution equals RotWord first.
    assign w_g = rot_word(w_sub_out) ^ {w_rc, 24'h000000};

    assign w_f0      = w_w0 ^ w_g;
    assign w_f1      = w_w1 ^ w_f0;
    assign w_f2      = w_w2 ^ w_f1;
    assign w_f3      = w_w3 ^ w_f2;
    assign w_fwd_key = {w_f0, w_f1, w_f2, w_f3};

    assign w_inv_key = {w_w0 ^ w_g, w_w1 ^ w_w0, w_w2 ^ w_w1, w_v3};

    // Next-state, key register and round counter update.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_d   = round_key_t'(key_in);
                    rnd_d   = 4'd1;
                    state_d = FWD;
                end
            end
            FWD: begin
                key_d = w_fwd_key;
                if (rnd_q == LAST_RND) begin
                    state_d = EMIT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (rnd_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        key_d = w_inv_key;
                        rnd_d = rnd_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, key and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q == FWD) || (state_q == EMIT);
    assign rk_valid  = (state_q == EMIT);
    assign rk_out    = KEY_W'(key_q);
    assign rk_idx    = (state_q == EMIT) ? rnd_q : 4'd0;
    assign rk_last   = (state_q == EMIT) && (rnd_q == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_key_sched
//  Description : Self-checking bench for aes_inv_key_sched. A textbook AES-128
//                key expansion (S-box derived from GF(2^8) arithmetic) feeds a
//                scoreboard that the per-cycle compare process checks against.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_inv_key_sched;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cyc = 0;
    int last_k0_cyc = -100;
    int n_acc    = 0;
    bit b2b_armed = 1'b0;

    logic [7:0]   sbox_m [256];
    logic [127:0] rk_fips [11];
    logic [127:0] rk_zero [11];
    exp_t         q [$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a   = 8'(i);
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_m[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // FIPS-197 KeyExpansion over 44 words, regrouped into 11 round keys.
    task automatic expand(input logic [127:0] k, output logic [127:0] rk [11]);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = sub_w({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        logic [127:0] rks [11];
        bit exp_busy;
        bit exp_valid;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            check("rst_key_ready", key_ready, 1);
            check("rst_rk_valid",  rk_valid,  0);
            check("rst_rk_out",    rk_out,    0);
            check("rst_rk_idx",    rk_idx,    0);
            check("rst_rk_last",   rk_last,   0);
            check("rst_busy",      busy,      0);
            q.delete();
        end else begin
            exp_busy  = (q.size() != 0);
            exp_valid = exp_busy && (cyc >= valid_cyc);
            check("key_ready", key_ready, !exp_busy);
            check("busy",      busy,      exp_busy);
            check("rk_valid",  rk_valid,  exp_valid);
            if (exp_valid) begin
                e = q[0];
                check("rk_idx",  rk_idx,  e.idx);
                check("rk_out",  rk_out,  e.key);
                check("rk_last", rk_last, e.idx == 4'd0);
                if (rk_ready) begin
                    void'(q.pop_front());
                    if (e.idx == 4'd0) last_k0_cyc = cyc;
                end
            end
            if (key_valid && !exp_busy) begin
                if (b2b_armed) check("b2b_accept_gap", cyc - last_k0_cyc, 1);
                expand(key_in, rks);
                for (int r = 10; r >= 0; r--) begin
                    e.idx = 4'(r);
                    e.key = rks[r];
                    q.push_back(e);
                end
                valid_cyc = cyc + 11;
                n_acc++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", q.size() == 0, 1);
    endtask

    task automatic wait_idx(input logic [3:0] idx, input int budget);
        int n = 0;
        while (!(rk_valid && rk_idx == idx) && n < budget) begin
            tick();
            n++;
        end
        check("wait_idx_timeout", rk_valid && rk_idx == idx, 1);
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int start_acc;
        int n;
        build_sbox();
        expand(FIPS_KEY, rk_fips);
        expand(128'h0, rk_zero);

        // Pin the model against hand-known values.
        check("model_sbox_00", sbox_m[8'h00], 8'h63);
        check("model_sbox_53", sbox_m[8'h53], 8'hed);
        check("model_fips_k10", rk_fips[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_fips_k1",  rk_fips[1],  128'ha0fafe1788542cb123a339392a6c7605);
        check("model_zero_k10", rk_zero[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check("model_zero_k1",  rk_zero[1],  128'h62636363626363636263636362636363);

        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // T1: FIPS key, rk_ready held high, cycle-exact timing.
        rk_ready = 1'b1;
        key_valid = 1'b1;
        key_in = FIPS_KEY;
        tick();
        key_valid = 1'b0;
        repeat (10) tick();
        check("t1_c11_valid", rk_valid, 1);
        check("t1_c11_idx",   rk_idx,   4'd10);
        check("t1_c11_out",   rk_out,   128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        repeat (9) tick();
        check("t1_k1_idx", rk_idx, 4'd1);
        check("t1_k1_out", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
        tick();
        check("t1_k0_out",  rk_out,  FIPS_KEY);
        check("t1_k0_last", rk_last, 1);
        tick();
        check("t1_c22_key_ready", key_ready, 1);

        // T2: all-zero key.
        key_valid = 1'b1;
        key_in = '0;
        tick();
        key_valid = 1'b0;
        repeat (10) tick();
        check("t2_k10_out", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        repeat (9) tick();
        check("t2_k1_out", rk_out, 128'h62636363626363636263636362636363);
        tick();
        check("t2_k0_out",  rk_out,  128'h0);
        check("t2_k0_last", rk_last, 1);
        wait_idle(40);

        // T3: backpressure at rk_idx 7.
        key_valid = 1'b1;
        key_in = FIPS_KEY;
        tick();
        key_valid = 1'b0;
        wait_idx(4'd7, 40);
        rk_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_valid", rk_valid, 1);
            check("t3_stall_idx",   rk_idx,   4'd7);
            check("t3_stall_out",   rk_out,   rk_fips[7]);
        end
        rk_ready = 1'b1;
        wait_idle(40);

        // T4: stray key_valid during FWD and EMIT with a different key.
        key_valid = 1'b1;
        key_in = FIPS_KEY;
        tick();
        key_valid = 1'b0;
        repeat (2) tick();
        key_valid = 1'b1;
        key_in = rand_key();
        check("t4_fwd_key_ready", key_ready, 0);
        tick();
        key_valid = 1'b0;
        repeat (10) tick();
        key_valid = 1'b1;
        check("t4_emit_key_ready", key_ready, 0);
        check("t4_emit_valid",     rk_valid,  1);
        tick();
        key_valid = 1'b0;
        wait_idle(40);

        // T5: asynchronous reset mid-EMIT at rk_idx 4, then a fresh key.
        key_valid = 1'b1;
        key_in = rand_key();
        tick();
        key_valid = 1'b0;
        wait_idx(4'd4, 40);
        rst_n = 1'b0;
        #1;
        check("t5_key_ready", key_ready, 1);
        check("t5_rk_valid",  rk_valid,  0);
        check("t5_rk_out",    rk_out,    0);
        check("t5_rk_idx",    rk_idx,    0);
        check("t5_rk_last",   rk_last,   0);
        check("t5_busy",      busy,      0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        key_valid = 1'b1;
        key_in = rand_key();
        tick();
        key_valid = 1'b0;
        wait_idle(40);

        // T6: back-to-back key pairs, key_valid held, random rk_ready stalls.
        for (int pair = 0; pair < 4; pair++) begin
            start_acc = n_acc;
            key_valid = 1'b1;
            key_in = rand_key();
            n = 0;
            while (n_acc < start_acc + 2 && n < 300) begin
                rk_ready = ($urandom_range(0, 3) != 0);
                tick();
                n++;
                if (n_acc == start_acc + 1 && !b2b_armed) begin
                    b2b_armed = 1'b1;
                    key_in = rand_key();
                end
            end
            check("t6_both_accepted", n_acc - start_acc, 2);
            key_valid = 1'b0;
            b2b_armed = 1'b0;
            n = 0;
            while (q.size() != 0 && n < 300) begin
                rk_ready = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
            check("t6_drain_timeout", q.size() == 0, 1);
        end
        rk_ready = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
